// File: rtl/falconsoar_pkg.sv
// Shared constants and types for the FalconSoar sampler datapath.
// Sizes the PRNG byte buffer between ChaCha20 and SamplerZ.
package falconsoar_pkg;

    localparam int PRNG_BLK_BYTES  = 64;
    localparam int PRNG_NUM_BLK    = 2;
    localparam int PRNG_CAP        = PRNG_BLK_BYTES * PRNG_NUM_BLK;
    localparam int SAMP_WIDE_BYTES = 10;

    typedef enum logic {
        PB_IDLE = 1'b0,
        PB_FILL = 1'b1
    } prng_buf_state_e;

endpackage

// File: rtl/prng_byte_extract.sv
// Combinational window of WIN consecutive bytes from a circular
// byte array, starting at ptr and wrapping modulo CAP.
module prng_byte_extract
    import falconsoar_pkg::*;
#(
    parameter int CAP = PRNG_CAP,
    parameter int WIN = SAMP_WIDE_BYTES + 1
) (
    input  logic [8*CAP-1:0]         mem,
    input  logic [$clog2(CAP)-1:0]   ptr,
    output logic [8*WIN-1:0]         win
);

    localparam int PW = $clog2(CAP);

    genvar i;
    for (i = 0; i < WIN; i++) begin : g_byte
        logic [PW-1:0] idx;
        assign idx = ptr + PW'(i);
        assign win[8*i +: 8] = mem[{idx, 3'b000} +: 8];
    end

endmodule

// File: rtl/prng_byte_buffer.sv
// Ping-pong byte buffer between the ChaCha20 PRNG and SamplerZ.
// Takes whole blocks in, serves 10-byte and 1-byte reads out.
module prng_byte_buffer
    import falconsoar_pkg::*;
#(
    parameter int BLK_BYTES  = PRNG_BLK_BYTES,
    parameter int NUM_BLK    = PRNG_NUM_BLK,
    parameter int WIDE_BYTES = SAMP_WIDE_BYTES
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           init_start,
    output logic                           init_done,
    output logic                           fetch_req,
    input  logic                           blk_valid,
    input  logic [8*BLK_BYTES-1:0]         blk_data,
    input  logic                           rd10_req,
    input  logic                           rd1_req,
    output logic [8*WIDE_BYTES-1:0]        rd10_data,
    output logic [7:0]                     rd1_data,
    output logic                           rd10_valid,
    output logic                           rd1_valid,
    output logic                           part_en,
    output logic [$clog2(BLK_BYTES*NUM_BLK+1)-1:0] level,
    output logic                           ovf_err
);

    localparam int CAP = BLK_BYTES * NUM_BLK;
    localparam int PW  = $clog2(CAP);
    localparam int LW  = $clog2(CAP + 1);
    localparam int WIN = WIDE_BYTES + 1;

    logic [8*CAP-1:0]        mem_q, mem_d;
    logic [PW-1:0]           ptr_q, ptr_d;
    logic [LW-1:0]           level_q, level_d;
    prng_buf_state_e         state_q, state_d;
    logic                    pend_q, pend_d;
    logic                    p10_q, p10_d;
    logic                    p1_q, p1_d;
    logic                    ovf_q, ovf_d;
    logic                    part_en_q, part_en_d;
    logic                    init_done_q, init_done_d;
    logic                    v10_q, v10_d;
    logic                    v1_q, v1_d;
    logic [8*WIDE_BYTES-1:0] d10_q, d10_d;
    logic [7:0]              d1_q, d1_d;

    logic                    accept;
    logic [PW-1:0]           tail;
    logic                    t10, t1;
    logic [LW:0]             need, avail;
    logic                    serve;
    logic [8*WIN-1:0]        win;

    assign fetch_req = rst_n & (level_q <= LW'(CAP - BLK_BYTES));
    assign accept    = blk_valid & fetch_req & ~init_start;
    assign tail      = ptr_q + PW'(level_q);
    assign t10       = pend_q ? p10_q : rd10_req;
    assign t1        = pend_q ? p1_q  : rd1_req;
    assign need      = (t10 ? (LW+1)'(WIDE_BYTES) : '0)
                     + (t1  ? (LW+1)'(1) : '0);
    assign avail     = (LW+1)'(level_q)
                     + (accept ? (LW+1)'(BLK_BYTES) : '0);
    assign serve     = (need != '0) & (state_q == PB_IDLE)
                     & (avail >= need) & ~init_start;

    prng_byte_extract #(
        .CAP (CAP),
        .WIN (WIN)
    ) u_extract (
        .mem (mem_d),
        .ptr (ptr_q),
        .win (win)
    );

    // Merge an accepted block into the free half at the tail
    always_comb begin
        mem_d = mem_q;
        for (int b = 0; b < NUM_BLK; b++) begin
            if (accept && tail == PW'(b * BLK_BYTES)) begin
                mem_d[8*BLK_BYTES*b +: 8*BLK_BYTES] = blk_data;
            end
        end
    end

    // Next-state: init flush, fill tracking, read service and stalls
    always_comb begin
        ptr_d       = ptr_q;
        level_d     = level_q;
        state_d     = state_q;
        pend_d      = pend_q;
        p10_d       = p10_q;
        p1_d        = p1_q;
        ovf_d       = ovf_q;
        part_en_d   = part_en_q;
        init_done_d = 1'b0;
        v10_d       = 1'b0;
        v1_d        = 1'b0;
        d10_d       = d10_q;
        d1_d        = d1_q;
        if (init_start) begin
            ptr_d     = '0;
            level_d   = '0;
            pend_d    = 1'b0;
            p10_d     = 1'b0;
            p1_d      = 1'b0;
            ovf_d     = 1'b0;
            part_en_d = 1'b1;
            state_d   = PB_FILL;
        end else begin
            if (blk_valid && !fetch_req) begin
                ovf_d = 1'b1;
            end
            if (state_q == PB_FILL && level_q == LW'(CAP)) begin
                state_d     = PB_IDLE;
                init_done_d = 1'b1;
            end
            if (serve) begin
                if (t10) begin
                    d10_d = win[8*WIDE_BYTES-1:0];
                end
                if (t1) begin
                    d1_d = t10 ? win[8*WIDE_BYTES +: 8] : win[7:0];
                end
                v10_d     = t10;
                v1_d      = t1;
                ptr_d     = ptr_q + PW'(need);
                level_d   = LW'(avail - need);
                pend_d    = 1'b0;
                part_en_d = 1'b1;
            end else begin
                level_d = LW'(avail);
                if (need != '0 && !pend_q) begin
                    pend_d    = 1'b1;
                    p10_d     = t10;
                    p1_d      = t1;
                    part_en_d = 1'b0;
                end
            end
        end
    end

    // Control and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            level_q     <= '0;
            state_q     <= PB_IDLE;
            pend_q      <= 1'b0;
            p10_q       <= 1'b0;
            p1_q        <= 1'b0;
            ovf_q       <= 1'b0;
            part_en_q   <= 1'b1;
            init_done_q <= 1'b0;
            v10_q       <= 1'b0;
            v1_q        <= 1'b0;
            d10_q       <= '0;
            d1_q        <= '0;
        end else begin
            ptr_q       <= ptr_d;
            level_q     <= level_d;
            state_q     <= state_d;
            pend_q      <= pend_d;
            p10_q       <= p10_d;
            p1_q        <= p1_d;
            ovf_q       <= ovf_d;
            part_en_q   <= part_en_d;
            init_done_q <= init_done_d;
            v10_q       <= v10_d;
            v1_q        <= v1_d;
            d10_q       <= d10_d;
            d1_q        <= d1_d;
        end
    end

    // Byte storage; contents are only meaningful below level
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign init_done  = init_done_q;
    assign rd10_data  = d10_q;
    assign rd1_data   = d1_q;
    assign rd10_valid = v10_q;
    assign rd1_valid  = v1_q;
    assign part_en    = part_en_q;
    assign level      = level_q;
    assign ovf_err    = ovf_q;

endmodule

// File: tb/tb_prng_byte_buffer.sv
// Self-checking bench for prng_byte_buffer.
// Reference model treats the buffer as a byte FIFO with a capacity.
module tb_prng_byte_buffer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         init_start = 1'b0;
    logic         init_done;
    logic         fetch_req;
    logic         blk_valid = 1'b0;
    logic [511:0] blk_data = '0;
    logic         rd10_req = 1'b0;
    logic         rd1_req = 1'b0;
    logic [79:0]  rd10_data;
    logic [7:0]   rd1_data;
    logic         rd10_valid;
    logic         rd1_valid;
    logic         part_en;
    logic [7:0]   level;
    logic         ovf_err;

    prng_byte_buffer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .init_start (init_start),
        .init_done  (init_done),
        .fetch_req  (fetch_req),
        .blk_valid  (blk_valid),
        .blk_data   (blk_data),
        .rd10_req   (rd10_req),
        .rd1_req    (rd1_req),
        .rd10_data  (rd10_data),
        .rd1_data   (rd1_data),
        .rd10_valid (rd10_valid),
        .rd1_valid  (rd1_valid),
        .part_en    (part_en),
        .level      (level),
        .ovf_err    (ovf_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0]  q[$];
    logic        m_pend, m_p10, m_p1, m_fill, m_ovf;
    logic [79:0] e_d10;
    logic [7:0]  e_d1;
    logic        e_v10, e_v1, e_part_en, e_init_done;

    wire [13:0] dut_st = {rd10_valid, rd1_valid, part_en, init_done,
                          ovf_err, fetch_req, level};

    function automatic logic [13:0] exp_st();
        logic fr;
        fr = (q.size() <= 64);
        return {e_v10, e_v1, e_part_en, e_init_done, m_ovf, fr,
                8'(q.size())};
    endfunction

    function automatic logic [511:0] blk_seq(input int base);
        logic [511:0] r;
        for (int k = 0; k < 64; k++) r[8*k +: 8] = 8'(base + k);
        return r;
    endfunction

    function automatic logic [511:0] blk_rand();
        logic [511:0] r;
        for (int k = 0; k < 16; k++) r[32*k +: 32] = $urandom();
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        m_pend = 0; m_p10 = 0; m_p1 = 0; m_fill = 0; m_ovf = 0;
        e_d10 = '0; e_d1 = '0;
        e_v10 = 0; e_v1 = 0; e_part_en = 1; e_init_done = 0;
    endtask

    task automatic tick(input logic bv, input logic [511:0] bd,
                        input logic r10, input logic r1, input logic is);
        logic was_fill, t10, t1;
        int n;
        @(negedge clk);
        blk_valid = bv; blk_data = bd;
        rd10_req = r10; rd1_req = r1; init_start = is;
        @(posedge clk);
        e_v10 = 0; e_v1 = 0; e_init_done = 0;
        if (is) begin
            q.delete();
            m_pend = 0; m_ovf = 0; m_fill = 1; e_part_en = 1;
        end else begin
            was_fill = m_fill;
            if (m_fill && q.size() == 128) begin
                m_fill = 0;
                e_init_done = 1;
            end
            if (bv) begin
                if (q.size() <= 64) begin
                    for (int k = 0; k < 64; k++) q.push_back(bd[8*k +: 8]);
                end else begin
                    m_ovf = 1;
                end
            end
            t10 = m_pend ? m_p10 : r10;
            t1  = m_pend ? m_p1  : r1;
            n = (t10 ? 10 : 0) + (t1 ? 1 : 0);
            if (n > 0 && !was_fill && q.size() >= n) begin
                if (t10) for (int k = 0; k < 10; k++) e_d10[8*k +: 8] = q.pop_front();
                if (t1) e_d1 = q.pop_front();
                e_v10 = t10; e_v1 = t1;
                e_part_en = 1; m_pend = 0;
            end else if (n > 0 && !m_pend) begin
                m_pend = 1; m_p10 = t10; m_p1 = t1; e_part_en = 0;
            end
        end
        #1;
        blk_valid = 0; rd10_req = 0; rd1_req = 0; init_start = 0;
    endtask

    task automatic idle();     tick(0, '0, 0, 0, 0); endtask
    task automatic rd(input logic a, input logic b); tick(0, '0, a, b, 0); endtask
    task automatic blk(input logic [511:0] d); tick(1, d, 0, 0, 0); endtask

    task automatic reset_hold();
        @(negedge clk);
        rst_n = 0;
        blk_valid = 0; rd10_req = 0; rd1_req = 0; init_start = 0;
        repeat (2) @(posedge clk);
        model_reset();
        #1;
    endtask

    task automatic reset_release();
        @(negedge clk);
        rst_n = 1;
        #1;
    endtask

    task automatic do_init(input int b0, input int b1);
        tick(0, '0, 0, 0, 1);
        blk(blk_seq(b0));
        blk(blk_seq(b1));
        idle();
        idle();
    endtask

    task automatic test_reset();
        reset_hold();
        checks++;
        if (dut_st !== 14'b00_1_0_0_0_00000000 || rd10_data !== '0 || rd1_data !== '0) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h d10=%h d1=%h",
                     dut_st, 14'b00_1_0_0_0_00000000, rd10_data, rd1_data);
        end
        reset_release();
        checks++;
        if (fetch_req !== 1'b1) begin
            failures++;
            $display("FAIL reset_fetch got=%b exp=1", fetch_req);
        end
    endtask

    task automatic test_init();
        int pulses;
        tick(0, '0, 0, 0, 1);
        blk(blk_seq(8'h00));
        checks++;
        if (level !== 8'd64 || fetch_req !== 1'b1) begin
            failures++;
            $display("FAIL init_blk1 got=%0d/%b exp=64/1", level, fetch_req);
        end
        blk(blk_seq(8'h40));
        checks++;
        if (level !== 8'd128 || fetch_req !== 1'b0) begin
            failures++;
            $display("FAIL init_blk2 got=%0d/%b exp=128/0", level, fetch_req);
        end
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            idle();
            if (init_done === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL init_done_pulses got=%0d exp=1", pulses);
        end
    endtask

    task automatic test_first_reads();
        rd(1, 0);
        checks++;
        if (rd10_valid !== 1'b1 || rd10_data !== 80'h09080706050403020100
            || level !== 8'd118) begin
            failures++;
            $display("FAIL first_rd10 got=%b/%h/%0d exp=1/%h/118",
                     rd10_valid, rd10_data, level, 80'h09080706050403020100);
        end
        rd(0, 1);
        checks++;
        if (rd1_valid !== 1'b1 || rd1_data !== 8'h0A || level !== 8'd117) begin
            failures++;
            $display("FAIL first_rd1 got=%b/%h/%0d exp=1/0a/117",
                     rd1_valid, rd1_data, level);
        end
    endtask

    task automatic test_wrap();
        do_init(8'h00, 8'h40);
        repeat (6) rd(1, 0);
        checks++;
        if (level !== 8'd68 || fetch_req !== 1'b0) begin
            failures++;
            $display("FAIL wrap_lvl68 got=%0d/%b exp=68/0", level, fetch_req);
        end
        rd(1, 0);
        checks++;
        if (rd10_data !== 80'h4544434241403F3E3D3C || level !== 8'd58
            || fetch_req !== 1'b1) begin
            failures++;
            $display("FAIL wrap_span got=%h/%0d/%b exp=%h/58/1",
                     rd10_data, level, fetch_req, 80'h4544434241403F3E3D3C);
        end
        blk(blk_seq(8'h80));
        checks++;
        if (level !== 8'd122) begin
            failures++;
            $display("FAIL wrap_refill got=%0d exp=122", level);
        end
        repeat (6) rd(1, 0);
        checks++;
        if (rd10_data !== 80'h81807F7E7D7C7B7A7978 || level !== 8'd62) begin
            failures++;
            $display("FAIL wrap_end got=%h/%0d exp=%h/62",
                     rd10_data, level, 80'h81807F7E7D7C7B7A7978);
        end
    endtask

    task automatic test_stall();
        repeat (5) rd(1, 0);
        repeat (7) rd(0, 1);
        rd(1, 0);
        checks++;
        if (part_en !== 1'b0 || rd10_valid !== 1'b0 || level !== 8'd5) begin
            failures++;
            $display("FAIL stall_enter got=%b/%b/%0d exp=0/0/5",
                     part_en, rd10_valid, level);
        end
        idle();
        rd(0, 1);
        checks++;
        if (part_en !== 1'b0 || rd1_valid !== 1'b0 || dut_st !== exp_st()) begin
            failures++;
            $display("FAIL stall_hold got=%h exp=%h", dut_st, exp_st());
        end
        blk(blk_rand());
        checks++;
        if (rd10_valid !== 1'b1 || part_en !== 1'b1 || level !== 8'd59
            || rd10_data !== e_d10) begin
            failures++;
            $display("FAIL stall_release got=%b/%b/%0d/%h exp=1/1/59/%h",
                     rd10_valid, part_en, level, rd10_data, e_d10);
        end
    endtask

    task automatic test_dual();
        blk(blk_rand());
        repeat (5) rd(1, 0);
        repeat (9) rd(0, 1);
        checks++;
        if (level !== 8'd64) begin
            failures++;
            $display("FAIL dual_setup got=%0d exp=64", level);
        end
        rd(1, 1);
        checks++;
        if (rd10_valid !== 1'b1 || rd1_valid !== 1'b1 || level !== 8'd53
            || rd10_data !== e_d10 || rd1_data !== e_d1) begin
            failures++;
            $display("FAIL dual_read got=%h/%h/%0d exp=%h/%h/53",
                     rd10_data, rd1_data, level, e_d10, e_d1);
        end
    endtask

    task automatic test_ovf();
        blk(blk_rand());
        repeat (5) rd(1, 0);
        repeat (3) rd(0, 1);
        blk(blk_rand());
        checks++;
        if (level !== 8'd128 || ovf_err !== 1'b0) begin
            failures++;
            $display("FAIL ovf_setup got=%0d/%b exp=128/0", level, ovf_err);
        end
        blk(blk_rand());
        checks++;
        if (ovf_err !== 1'b1 || level !== 8'd128) begin
            failures++;
            $display("FAIL ovf_set got=%b/%0d exp=1/128", ovf_err, level);
        end
        tick(0, '0, 0, 0, 1);
        checks++;
        if (ovf_err !== 1'b0 || level !== 8'd0) begin
            failures++;
            $display("FAIL ovf_clear got=%b/%0d exp=0/0", ovf_err, level);
        end
    endtask

    task automatic test_random();
        logic bv, r10, r1, is;
        do_init($urandom_range(0, 255), $urandom_range(0, 255));
        for (int i = 0; i < 600; i++) begin
            bv  = ($urandom_range(0, 2) == 0);
            is  = ($urandom_range(0, 149) == 0);
            r10 = 0; r1 = 0;
            if (!m_pend && !is) begin
                r10 = ($urandom_range(0, 2) == 0);
                r1  = ($urandom_range(0, 3) == 0);
            end
            tick(bv, blk_rand(), r10, r1, is);
            checks++;
            if (dut_st !== exp_st() || rd10_data !== e_d10 || rd1_data !== e_d1) begin
                failures++;
                $display("FAIL random_cyc%0d got=%h/%h/%h exp=%h/%h/%h",
                         i, dut_st, rd10_data, rd1_data, exp_st(), e_d10, e_d1);
            end
        end
    endtask

    task automatic test_reset_mid_fill();
        int pulses;
        tick(0, '0, 0, 0, 1);
        blk(blk_rand());
        reset_hold();
        checks++;
        if (dut_st !== 14'b00_1_0_0_0_00000000 || rd10_data !== '0 || rd1_data !== '0) begin
            failures++;
            $display("FAIL midfill_reset got=%h exp=%h", dut_st, 14'b00_1_0_0_0_00000000);
        end
        reset_release();
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            idle();
            if (init_done === 1'b1 || rd10_valid === 1'b1 || rd1_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || level !== 8'd0) begin
            failures++;
            $display("FAIL midfill_quiet got=%0d/%0d exp=0/0", pulses, level);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        test_reset();
        test_init();
        test_first_reads();
        test_wrap();
        test_stall();
        test_dual();
        test_ovf();
        test_random();
        test_reset_mid_fill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
